// File: rtl/reset_sequencer_if.sv
// Reset sequencer status/control bundle: lock and software request in,
// sequenced domain resets and reset bookkeeping out.
interface reset_sequencer_if #(
  parameter int NumDomains = 3
);
  logic                  pll_locked;
  logic                  sw_reset_req;
  logic [NumDomains-1:0] domain_reset;
  logic                  ready;
  logic [1:0]            last_cause;
  logic [7:0]            reset_events;

  // Driver of lock/request, consumer of the reset outputs
  modport master (
    output pll_locked, sw_reset_req,
    input  domain_reset, ready, last_cause, reset_events
  );

  // The sequencer itself
  modport slave (
    input  pll_locked, sw_reset_req,
    output domain_reset, ready, last_cause, reset_events
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domains in reset for a minimum time, waits for
// a stable synchronized PLL lock, then releases domains one at a time in
// ascending order. Lock loss or a software request restarts the sequence.
module reset_sequencer #(
  parameter int NumDomains = 3,
  parameter int HoldCycles = 16,
  parameter int LockCycles = 100,
  parameter int StepCycles = 8
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  reset_sequencer_if.slave bus
);

  localparam int MaxHL  = (HoldCycles > LockCycles) ? HoldCycles : LockCycles;
  localparam int MaxCyc = (MaxHL > StepCycles) ? MaxHL : StepCycles;
  localparam int CntW   = $clog2(MaxCyc + 1);
  localparam int IdxW   = $clog2(NumDomains + 1);

  localparam logic [1:0] CauseLock = 2'd1;
  localparam logic [1:0] CauseSw   = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  logic [1:0]            r_sync;
  state_e                r_state, w_state;
  logic [CntW-1:0]       r_cnt, w_cnt;
  logic [IdxW-1:0]       r_idx, w_idx;
  logic [NumDomains-1:0] r_dom, w_dom;
  logic                  r_ready, w_ready;
  logic [1:0]            r_cause, w_cause;
  logic [7:0]            r_events, w_events;
  logic                  w_lock_s;
  logic                  w_abort;
  logic [1:0]            w_abort_cause;

  assign w_lock_s = r_sync[1];

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], bus.pll_locked};
  end

  // State and all registered outputs
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_ASSERT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_dom    <= '1;
      r_ready  <= 1'b0;
      r_cause  <= 2'd0;
      r_events <= 8'd0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_dom    <= w_dom;
      r_ready  <= w_ready;
      r_cause  <= w_cause;
      r_events <= w_events;
    end
  end

  // Next-state: hold timer, lock qualification, stepped release, restart
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_idx         = r_idx;
    w_dom         = r_dom;
    w_ready       = r_ready;
    w_cause       = r_cause;
    w_events      = r_events;
    w_abort       = 1'b0;
    w_abort_cause = CauseSw;

    case (r_state)
      ST_ASSERT: begin
        // Lock and request are deliberately ignored while held
        w_dom = '1;
        if (r_cnt == CntW'(HoldCycles - 1)) begin
          w_state = ST_WAIT_LOCK;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (bus.sw_reset_req) begin
          w_abort = 1'b1;
        end else if (!w_lock_s) begin
          // A lock glitch only restarts qualification
          w_cnt = '0;
        end else if (r_cnt == CntW'(LockCycles - 1)) begin
          w_dom[0] = 1'b0;
          w_idx    = IdxW'(1);
          w_cnt    = '0;
          if (NumDomains == 1) begin
            w_state = ST_RUN;
            w_ready = 1'b1;
          end else begin
            w_state = ST_RELEASE;
          end
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end

      ST_RELEASE: begin
        if (bus.sw_reset_req) begin
          w_abort = 1'b1;
        end else if (!w_lock_s) begin
          w_abort       = 1'b1;
          w_abort_cause = CauseLock;
        end else if (r_cnt == CntW'(StepCycles - 1)) begin
          for (int d = 0; d < NumDomains; d++)
            if (IdxW'(d) == r_idx) w_dom[d] = 1'b0;
          w_idx = r_idx + IdxW'(1);
          w_cnt = '0;
          if (r_idx == IdxW'(NumDomains - 1)) begin
            w_state = ST_RUN;
            w_ready = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
      end

      ST_RUN: begin
        if (bus.sw_reset_req) begin
          w_abort = 1'b1;
        end else if (!w_lock_s) begin
          w_abort       = 1'b1;
          w_abort_cause = CauseLock;
        end
      end

      default: w_state = ST_ASSERT;
    endcase

    // Restart: software wins over lock loss when both arrive together
    if (w_abort) begin
      w_state = ST_ASSERT;
      w_dom   = '1;
      w_ready = 1'b0;
      w_cnt   = '0;
      w_idx   = '0;
      w_cause = w_abort_cause;
      if (r_events != 8'hFF) w_events = r_events + 8'd1;
    end
  end

  assign bus.domain_reset = r_dom;
  assign bus.ready        = r_ready;
  assign bus.last_cause   = r_cause;
  assign bus.reset_events = r_events;

endmodule
